gpio_mmio: RTL
==============

Name: gpio_mmio

Overview:
Parametrised memory-mapped GPIO peripheral on the single-cycle core's data bus. Generalises the fixed 4-LED output and switch/IR input paths to N_OUT outputs and N_IN inputs. Adds per-input synchronisation and debounce, sticky edge flags with write-one-to-clear, and a maskable interrupt. Sits beside the data RAM. It decodes a 4-word window and passes all other accesses through to RAM.

Parameters:
DATA_W, 32, bus data width
ADDR_W, 5, word-address width (core drives ALUResult[ADDR_W-1:0])
BASE, 28, word address of register 0; must be 4-aligned
N_OUT, 4, output pins (1..DATA_W)
N_IN, 6, input pins (1..DATA_W); switches plus IR
SYNC_STAGES, 2, synchroniser flops per input (>=2)
DB_CYCLES, 4, consecutive stable cycles required before a debounced value changes (>=1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
addr  in  ADDR_W  word address from ALU result
wdata  in  DATA_W  store data (register-file RD2)
we  in  1  store strobe (MemWrite)
rdata_mem  in  DATA_W  read data from RAM
rdata  out  DATA_W  read data to result mux
mem_we  out  1  write enable forwarded to RAM
gpio_in  in  N_IN  asynchronous input pins
gpio_out  out  N_OUT  output pins (LEDs)
irq  out  1  interrupt request

Behaviour:
- hit = (addr[ADDR_W-1:2] == BASE[ADDR_W-1:2]); off = addr[1:0]. mem_we = we & ~hit, so RAM is never written inside the window.
- Register map by off:
  - 0 OUT: R/W, N_OUT bits
  - 1 IN: read-only debounced inputs; writes ignored
  - 2 FLAG: sticky edge flags, write-1-to-clear
  - 3 IEN: R/W interrupt enable, N_IN bits
- Reads are combinational, with no side effects.
  - hit: rdata = selected register, zero-extended to DATA_W.
  - ~hit: rdata = rdata_mem.
- Writes take effect on the rising clk edge where we & hit; upper wdata bits are ignored.
- gpio_out is driven directly from the OUT register.
- Per input channel:
  - SYNC_STAGES-flop synchroniser feeds a debouncer holding stable[i] and a counter of width clog2(DB_CYCLES+1).
  - Each edge: if sync != stable, count increments; on the DB_CYCLES-th consecutive mismatch, stable flips and count clears.
  - If sync == stable, count clears.
  - Latency: a pin change held steady appears in IN on the (SYNC_STAGES+DB_CYCLES)-th rising edge after it is first sampled. Defaults: 6 edges.
  - A pulse shorter than DB_CYCLES synchronised cycles is never seen.
- Flags:
  - flag[i] sets on the same edge that stable[i] goes 0->1.
  - A W1C write clears the written-1 bits.
  - If set and clear coincide on the same bit, set wins.
- irq = |(flag & ien), combinational from flops.
- Reset (reset=0, asynchronous, no clock needed) clears: OUT, IN/stable, sync flops, counters, FLAG, IEN. Hence gpio_out=0 and irq=0.
- Reset released mid-debounce: the channel restarts from stable=0, count=0.

Optional Feature:
GPIO_FALL_EDGE_EN
- Defined: flag[i] also sets when stable[i] goes 1->0 (any-edge capture); set-over-clear priority is unchanged.
- Undefined: flags set on rising debounced edges only.

Decomposition:
- Package gpio_pkg holds:
  - register offsets OFF_OUT=0, OFF_IN=1, OFF_FLAG=2, OFF_IEN=3
  - window size constant 4
- Sub-module gpio_debounce: one channel (synchroniser plus counter plus stable bit, with a rise/fall pulse output). Instantiated N_IN times via generate.
- Top level holds the decode, registers and read mux.

Test Plan:
1. Reset, then we=1, addr=28, wdata=0x0000000A -> gpio_out=4'hA after that edge; mem_we=0 during the store; read addr=28 returns 0x0000000A.
2. gpio_in[0] 0->1 held -> read addr=29 shows bit0=0 after 5 edges and 1 after 6 edges; FLAG (addr=30) bit0=1 on the same edge.
3. gpio_in[1] high for 3 cycles, then low -> IN bit1 stays 0; FLAG stays 0x0.
4. Write 0x01 to addr 31, then rise gpio_in[0] -> irq=1.
   - Write 0x01 to addr 30 -> flag0 and irq clear after that edge.
   - Repeat with the W1C landing on the set edge -> flag0 stays 1.
5. we=1, addr=5, wdata=0x3, rdata_mem=0xDEADBEEF -> mem_we=1, rdata=0xDEADBEEF, gpio_out unchanged.
6. Assert reset low between clock edges while a count is in progress -> gpio_out=0, FLAG=0, irq=0 immediately.
   - With GPIO_FALL_EDGE_EN: a debounced 1->0 on gpio_in[2] sets flag2; without it, flag2 stays 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared register map for the memory-mapped GPIO block.
package gpio_pkg;

   localparam logic [1:0] OFF_OUT  = 2'd0;
   localparam logic [1:0] OFF_IN   = 2'd1;
   localparam logic [1:0] OFF_FLAG = 2'd2;
   localparam logic [1:0] OFF_IEN  = 2'd3;

   localparam int WINDOW_WORDS = 4;
   localparam int WINDOW_BITS  = $clog2(WINDOW_WORDS);

endpackage

// File: rtl/gpio_debounce.sv
// One input channel: synchroniser chain, stability counter and debounced bit,
// with single-cycle pulses on the edge where the debounced value flips.
module gpio_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_pin,
   output logic o_stable,
   output logic o_rise,
   output logic o_fall
);

   localparam int              CW   = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0]   LAST = CW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_count;
   logic                   r_stable;
   logic                   w_sync;
   logic                   w_mismatch;
   logic                   w_flip;

   assign w_sync     = r_sync[SYNC_STAGES-1];
   assign w_mismatch = w_sync ^ r_stable;
   // The DB_CYCLES-th consecutive mismatch is the one seen while the count reads DB_CYCLES-1.
   assign w_flip     = w_mismatch && (r_count == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync   <= '0;
         r_count  <= '0;
         r_stable <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
         if (w_flip) begin
            r_stable <= ~r_stable;
            r_count  <= '0;
         end else if (w_mismatch) begin
            r_count <= r_count + 1'b1;
         end else begin
            r_count <= '0;
         end
      end
   end

   assign o_stable = r_stable;
   assign o_rise   = w_flip & ~r_stable;
   assign o_fall   = w_flip &  r_stable;

endmodule

// File: rtl/gpio_mmio.sv
// GPIO window on the data bus: OUT / IN / FLAG (W1C) / IEN registers, RAM pass-through.
// Define GPIO_FALL_EDGE_EN to make flags capture falling debounced edges as well.
module gpio_mmio
   import gpio_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int BASE        = 28,
   parameter int N_OUT       = 4,
   parameter int N_IN        = 6,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              we,
   input  logic [DATA_W-1:0] rdata_mem,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_we,
   input  logic [N_IN-1:0]   gpio_in,
   output logic [N_OUT-1:0]  gpio_out,
   output logic              irq
);

   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

   logic [N_OUT-1:0] r_out;
   logic [N_IN-1:0]  r_flag;
   logic [N_IN-1:0]  r_ien;

   logic             w_hit;
   logic [1:0]       w_off;
   logic             w_wr;
   logic [N_IN-1:0]  w_in;
   logic [N_IN-1:0]  w_rise;
   logic [N_IN-1:0]  w_fall;
   logic [N_IN-1:0]  w_set;
   logic [N_IN-1:0]  w_clr;
   logic             w_unused_ok;

   assign w_hit  = (addr[ADDR_W-1:WINDOW_BITS] == BASE_A[ADDR_W-1:WINDOW_BITS]);
   assign w_off  = addr[WINDOW_BITS-1:0];
   assign w_wr   = we & w_hit;
   assign mem_we = we & ~w_hit;

   for (genvar g = 0; g < N_IN; g++) begin : g_ch
      gpio_debounce #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES)
      ) u_db (
         .clk      (clk),
         .reset    (reset),
         .i_pin    (gpio_in[g]),
         .o_stable (w_in[g]),
         .o_rise   (w_rise[g]),
         .o_fall   (w_fall[g])
      );
   end

`ifdef GPIO_FALL_EDGE_EN
   assign w_set = w_rise | w_fall;
`else
   assign w_set = w_rise;
`endif

   assign w_clr = (w_wr && (w_off == OFF_FLAG)) ? wdata[N_IN-1:0] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out  <= '0;
         r_flag <= '0;
         r_ien  <= '0;
      end else begin
         if (w_wr && (w_off == OFF_OUT)) r_out <= wdata[N_OUT-1:0];
         if (w_wr && (w_off == OFF_IEN)) r_ien <= wdata[N_IN-1:0];
         // Clear first, then OR in new edges so a coinciding set survives the W1C.
         r_flag <= (r_flag & ~w_clr) | w_set;
      end
   end

   always_comb begin
      rdata = '0;
      if (w_hit) begin
         case (w_off)
            OFF_OUT:  rdata[N_OUT-1:0] = r_out;
            OFF_IN:   rdata[N_IN-1:0]  = w_in;
            OFF_FLAG: rdata[N_IN-1:0]  = r_flag;
            default:  rdata[N_IN-1:0]  = r_ien;
         endcase
      end else begin
         rdata = rdata_mem;
      end
   end

   assign gpio_out = r_out;
   assign irq      = |(r_flag & r_ien);

   assign w_unused_ok = &{1'b0, wdata, w_fall};

endmodule
